instr_fetch: RTL and testbench

//  Fetch stage ahead of the decode/controller. Holds the PC and issues one instruction-memory

---
 rtl/core_pkg.sv | 25 ++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch FSM states (request / wait for response / hold for decode)
//   RESET_PC_DEFAULT : PC loaded on reset unless the instance overrides it
//   PC_STEP          : byte increment between sequential instructions
//   word_misaligned  : flags a byte address that is not on a 4-byte boundary
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Non-zero low address bits mean the target is not a word address.
    function automatic logic word_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage : core_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage ahead of decode. Holds the PC, keeps at most one instruction
// memory request in flight, and presents the returned word to decode through a
// valid/ready handshake. A redirect (pc_src/pc_target) overrides the
// sequential PC in every state; a request that is already in flight when the
// redirect arrives has its response discarded.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready/addr : fetch request channel, addr is always the PC
//   imem_rsp_valid/data       : one response per accepted request
//   instr_valid/ready, instr, instr_pc : instruction handed to decode
//   pc_src, pc_target : redirect request and target byte address
//   fetch_fault       : one-cycle pulse after a redirect to a misaligned target
// -----------------------------------------------------------------------------
module instr_fetch
    import core_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            req_valid_q, req_valid_d;
    logic            fault_q, fault_d;

    logic            req_fire_s;
    logic            instr_fire_s;
    logic [XLEN-1:0] redirect_pc_s;

    // Handshake decodes and the word-aligned redirect target.
    always_comb begin
        req_fire_s    = req_valid_q & imem_req_ready;
        instr_fire_s  = instr_valid_q & instr_ready;
        redirect_pc_s = {pc_target[XLEN-1:2], 2'b00};
    end

    // Next-state logic for the fetch FSM, PC and held instruction.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = pc_src & word_misaligned(pc_target[1:0]);

        case (state_q)
            S_REQ: begin
                // A redirect in the acceptance cycle means the word coming
                // back belongs to the old path and must be thrown away.
                if (req_fire_s) begin
                    state_d = S_WAIT;
                    drop_d  = pc_src;
                end else begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q | pc_src) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        drop_d     = 1'b0;
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                    end
                end else begin
                    state_d = S_WAIT;
                    drop_d  = drop_q | pc_src;
                end
            end
            S_HOLD: begin
                // A redirect squashes the held word; if decode takes it in
                // the same cycle it still counts as consumed.
                if (instr_fire_s | pc_src) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
                drop_d = 1'b0;
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase

        if (pc_src) begin
            pc_d = redirect_pc_s;
        end else if ((state_q == S_HOLD) && instr_fire_s) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end else begin
            pc_d = pc_q;
        end

        // Outputs are registered copies of the decoded next state.
        req_valid_d   = (state_d == S_REQ);
        instr_valid_d = (state_d == S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_valid_q   <= req_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = fault_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: a per-cycle vector table for the
// directed scenarios, hand sequences for PC wrap and mid-fetch reset, and a
// randomized run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC_DEFAULT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .pc_src(pc_src), .pc_target(pc_target),
        .fetch_fault(fetch_fault)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: next fetch address, the request in flight, the word
    // waiting for decode, and the expected fault pulse.
    logic [31:0] m_pc, m_out_addr, m_ipc, m_instr;
    bit          m_out, m_squash, m_have, m_first, m_fault;
    int          rsp_cnt;

    typedef struct {
        bit          rr, rv, ir, src;
        logic [31:0] tgt;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_ipc;
        bit          e_f;
    } vec_t;
    vec_t tbl[25];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input int i, input bit rr, input bit rv, input bit ir, input bit src,
                       input logic [31:0] tgt, input bit erv, input logic [31:0] eaddr,
                       input bit eiv, input logic [31:0] eipc, input bit ef);
        tbl[i] = '{rr, rv, ir, src, tgt, erv, eaddr, eiv, eipc, ef};
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC_DEFAULT;
        m_out    = 1'b0;
        m_squash = 1'b0;
        m_have   = 1'b0;
        m_first  = 1'b1;
        m_fault  = 1'b0;
        rsp_cnt  = 0;
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model,
    // cross the rising edge and compare at the following negedge.
    task automatic step(input bit rr, input bit rv, input bit ir, input bit src,
                        input logic [31:0] tgt);
        bit exp_rv, fire, hs;
        exp_rv = !m_out && !m_have && !m_first;
        fire   = exp_rv && rr;
        hs     = m_have && ir;

        imem_req_ready = rr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? (m_out ? memword(m_out_addr) : 32'hDEAD_BEEF) : 32'h0000_0000;
        instr_ready    = ir;
        pc_src         = src;
        pc_target      = tgt;

        m_fault = src && (tgt[1:0] != 2'b00);
        if (m_have && (ir || src)) m_have = 1'b0;
        if (m_out && rv) begin
            if (!(m_squash || src)) begin
                m_have  = 1'b1;
                m_ipc   = m_out_addr;
                m_instr = memword(m_out_addr);
            end
            m_out = 1'b0;
        end else if (m_out && src) begin
            m_squash = 1'b1;
        end
        if (fire) begin
            m_out      = 1'b1;
            m_out_addr = m_pc;
            m_squash   = src;
            rsp_cnt    = $urandom_range(0, 2);
        end
        if (src)     m_pc = {tgt[31:2], 2'b00};
        else if (hs) m_pc = m_pc + 32'd4;
        m_first = 1'b0;

        @(posedge clk);
        @(negedge clk);

        exp_rv = !m_out && !m_have;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_have));
        if (m_have) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endtask

    bit          r_rv, r_src;
    logic [31:0] r_tgt;

    initial begin
        // Directed per-cycle vectors: inputs for one cycle, outputs after it.
        row( 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0);
        row( 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row( 2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   1'b0);
        row( 3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   1'b0);
        row( 4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row( 5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   1'b0);
        row( 6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0,   1'b0);
        row( 7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row( 8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h302, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
        row( 9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   1'b0);
        row(10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   1'b0);
        row(11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row(12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0);
        for (int i = 13; i <= 17; i++)
            row(i, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h300, 1'b0);
        row(18, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h0,   1'b0);
        row(19, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row(20, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0);
        row(21, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
        row(22, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0);
        row(23, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0);
        row(24, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0);

        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_addr", imem_req_addr, RESET_PC_DEFAULT);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].rr, tbl[i].rv, tbl[i].ir, tbl[i].src, tbl[i].tgt);
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
            chk($sformatf("tbl%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].e_f));
        end

        // PC wrap: fetch and consume the last word of the address space.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // Reset while waiting for a response; the late response is ignored.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst_instr_valid", 32'(instr_valid), 32'h0);
        chk("midrst_addr", imem_req_addr, RESET_PC_DEFAULT);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("late_rsp_addr", imem_req_addr, RESET_PC_DEFAULT);
        chk("late_rsp_instr_valid", 32'(instr_valid), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r_rv = 1'b0;
            if (m_out) begin
                if (rsp_cnt == 0) r_rv = 1'b1;
                else rsp_cnt--;
            end else if ($urandom_range(0, 19) == 0) begin
                r_rv = 1'b1;
            end
            r_src = ($urandom_range(0, 9) == 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 1) == 1) r_tgt[1:0] = 2'b00;
            step(($urandom_range(0, 3) != 0), r_rv, ($urandom_range(0, 2) != 0), r_src, r_tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instr_fetch
